// File: rtl/load_align_unit.sv
// Load unit: issues one aligned memory read per load, then lane-selects and
// sign/zero-extends the returned data, reporting misaligned/illegal/bus/timeout errors.
module load_align_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_type,
  input  logic [4:0]        ld_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [XLEN-1:0]   res_data,
  output logic [4:0]        res_rd,
  output logic              res_err,
  output logic [1:0]        res_err_code
);

  // state | meaning
  // IDLE  | ready for a load request
  // REQ   | aligned read request held until memory accepts it
  // WAIT  | waiting for read data, timeout counter running
  // RESP  | result (or error) presented until consumer accepts it

  localparam int OFFS  = $clog2(XLEN / 8);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [2:0] T_LB  = 3'b000;
  localparam logic [2:0] T_LH  = 3'b001;
  localparam logic [2:0] T_LW  = 3'b010;
  localparam logic [2:0] T_LD  = 3'b011;
  localparam logic [2:0] T_LBU = 3'b100;
  localparam logic [2:0] T_LHU = 3'b101;
  localparam logic [2:0] T_LWU = 3'b110;

  localparam logic [1:0] ERR_MISAL   = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [OFFS-1:0]   offs_q;
  logic [2:0]        type_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt;

  logic              req_illegal;
  logic              req_misal;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   ext;

  logic              cap;
  logic              cap_err;
  logic [1:0]        cap_code;
  logic [XLEN-1:0]   cap_data;
  logic [4:0]        cap_rd;

  // Request classification on the incoming (not yet latched) request.
  always_comb begin
    req_illegal = (ld_type == 3'b111) ||
                  ((XLEN == 32) && ((ld_type == T_LD) || (ld_type == T_LWU)));
    req_misal = 1'b0;
    case (ld_type)
      T_LH, T_LHU: req_misal = ld_addr[0];
      T_LW, T_LWU: req_misal = |ld_addr[1:0];
      T_LD:        req_misal = |ld_addr[2:0];
      default:     req_misal = 1'b0;
    endcase
  end

  always_comb begin
    lane = mem_rsp_data >> {offs_q, 3'b000};
    ext  = lane;
    case (type_q)
      T_LB:    ext = XLEN'($signed(lane[7:0]));
      T_LBU:   ext = XLEN'(lane[7:0]);
      T_LH:    ext = XLEN'($signed(lane[15:0]));
      T_LHU:   ext = XLEN'(lane[15:0]);
      T_LW:    ext = XLEN'($signed(lane[31:0]));
      T_LWU:   ext = XLEN'(lane[31:0]);
      default: ext = lane;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    ld_ready      = 1'b0;
    mem_req_valid = 1'b0;
    cap           = 1'b0;
    cap_err       = 1'b0;
    cap_code      = ERR_MISAL;
    cap_data      = '0;
    cap_rd        = rd_q;
    case (state)
      IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          cap_rd = ld_rd;
          if (req_illegal) begin
            state_nxt = RESP;
            cap       = 1'b1;
            cap_err   = 1'b1;
            cap_code  = ERR_ILLEGAL;
          end else if (req_misal) begin
            state_nxt = RESP;
            cap       = 1'b1;
            cap_err   = 1'b1;
            cap_code  = ERR_MISAL;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        // A response in the expiry cycle takes precedence over the timeout.
        if (mem_rsp_valid) begin
          state_nxt = RESP;
          cap       = 1'b1;
          cap_err   = mem_rsp_err;
          cap_code  = mem_rsp_err ? ERR_BUS : 2'b00;
          cap_data  = mem_rsp_err ? '0 : ext;
        end else if ((TIMEOUT > 0) && (cnt == TO_LAST)) begin
          state_nxt = RESP;
          cap       = 1'b1;
          cap_err   = 1'b1;
          cap_code  = ERR_TIMEOUT;
        end
      end
      RESP: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign res_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offs_q       <= '0;
      type_q       <= '0;
      rd_q         <= '0;
      mem_req_addr <= '0;
      cnt          <= '0;
      res_data     <= '0;
      res_rd       <= '0;
      res_err      <= 1'b0;
      res_err_code <= 2'b00;
    end else begin
      if ((state == IDLE) && ld_valid) begin
        offs_q       <= ld_addr[OFFS-1:0];
        type_q       <= ld_type;
        rd_q         <= ld_rd;
        mem_req_addr <= {ld_addr[ADDR_W-1:OFFS], {OFFS{1'b0}}};
      end
      if (state == REQ)       cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (cap) begin
        res_data     <= cap_data;
        res_rd       <= cap_rd;
        res_err      <= cap_err;
        res_err_code <= cap_code;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance,
// directed loads checked against literals and against a behavioural load model.
module tb_load_align_unit;

  localparam int TO = 4;

  typedef struct packed {
    logic        mem;
    logic        err;
    logic [1:0]  code;
    logic [63:0] data;
    logic [63:0] maddr;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        ld_valid, ld_ready, mem_req_valid, mem_req_ready;
  logic [31:0] ld_addr, mem_req_addr, mem_rsp_data, res_data;
  logic [2:0]  ld_type;
  logic [4:0]  ld_rd, res_rd;
  logic        mem_rsp_valid, mem_rsp_err, res_valid, res_ready, res_err;
  logic [1:0]  res_err_code;

  logic        w_ld_valid, w_ld_ready, w_mem_req_valid, w_mem_req_ready;
  logic [31:0] w_ld_addr, w_mem_req_addr;
  logic [63:0] w_mem_rsp_data, w_res_data;
  logic [2:0]  w_ld_type;
  logic [4:0]  w_ld_rd, w_res_rd;
  logic        w_mem_rsp_valid, w_mem_rsp_err, w_res_valid, w_res_ready, w_res_err;
  logic [1:0]  w_res_err_code;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp32    = '0;
  exp_t exp64    = '0;
  logic [4:0] exp32_rd = '0;
  logic [4:0] exp64_rd = '0;

  load_align_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_type(ld_type), .ld_rd(ld_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .res_err(res_err), .res_err_code(res_err_code)
  );

  load_align_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(w_ld_valid), .ld_ready(w_ld_ready), .ld_addr(w_ld_addr), .ld_type(w_ld_type),
    .ld_rd(w_ld_rd),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready),
    .mem_req_addr(w_mem_req_addr),
    .mem_rsp_valid(w_mem_rsp_valid), .mem_rsp_data(w_mem_rsp_data), .mem_rsp_err(w_mem_rsp_err),
    .res_valid(w_res_valid), .res_ready(w_res_ready), .res_data(w_res_data), .res_rd(w_res_rd),
    .res_err(w_res_err), .res_err_code(w_res_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // What a load must produce, from the ISA rules: pick the bytes, then extend.
  function automatic exp_t model(input int xlen, input logic [2:0] t, input logic [63:0] a,
                                 input logic [63:0] d, input bit e);
    exp_t r;
    int nb;
    bit sgn;
    int off;
    logic [63:0] mask, v;
    r = '0;
    r.maddr = a & ~64'(xlen / 8 - 1);
    nb = 0;
    sgn = 1'b0;
    case (t)
      3'd0: begin nb = 1; sgn = 1'b1; end
      3'd1: begin nb = 2; sgn = 1'b1; end
      3'd2: begin nb = 4; sgn = 1'b1; end
      3'd3: begin nb = 8; sgn = 1'b1; end
      3'd4: begin nb = 1; sgn = 1'b0; end
      3'd5: begin nb = 2; sgn = 1'b0; end
      3'd6: begin nb = 4; sgn = 1'b0; end
      default: nb = 0;
    endcase
    if (nb == 0 || (xlen == 32 && (nb == 8 || t == 3'd6))) begin
      r.err = 1'b1; r.code = 2'd1;
    end else if ((a % nb) != 0) begin
      r.err = 1'b1; r.code = 2'd0;
    end else if (e) begin
      r.mem = 1'b1; r.err = 1'b1; r.code = 2'd2;
    end else begin
      r.mem = 1'b1;
      off  = int'(a % (xlen / 8));
      v    = d >> (8 * off);
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
      v    = v & mask;
      if (sgn && v[8 * nb - 1]) v = v | ~mask;
      if (xlen == 32) v = v & 64'hFFFF_FFFF;
      r.data = v;
    end
    return r;
  endfunction

  // Continuous comparison of both instances against the current expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_valid) begin
        check("m32_req_expected", mem_req_valid, exp32.mem);
        check("m32_req_addr", mem_req_addr, exp32.maddr[31:0]);
      end
      if (res_valid) begin
        check("m32_res_data", res_data, exp32.data[31:0]);
        check("m32_res_err", {res_err, res_err_code}, {exp32.err, exp32.code});
        check("m32_res_rd", res_rd, exp32_rd);
      end
      if (ld_ready) check("m32_ready_excl", mem_req_valid | res_valid, 1'b0);
      if (w_mem_req_valid) begin
        check("m64_req_expected", w_mem_req_valid, exp64.mem);
        check("m64_req_addr", w_mem_req_addr, exp64.maddr[31:0]);
      end
      if (w_res_valid) begin
        check("m64_res_data", w_res_data, exp64.data);
        check("m64_res_err", {w_res_err, w_res_err_code}, {exp64.err, exp64.code});
        check("m64_res_rd", w_res_rd, exp64_rd);
      end
    end
  end

  // rsp_wait < 0 means the memory never answers (timeout path).
  task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] d, input bit e, input int req_wait,
                          input int rsp_wait, input int res_wait, input logic [31:0] lit,
                          input logic [1:0] lit_code, input bit lit_err);
    int t0;
    int n;
    int lat;
    exp32 = model(32, t, {32'd0, a}, {32'd0, d}, e);
    if (rsp_wait < 0) begin
      exp32.err  = 1'b1;
      exp32.code = 2'd3;
      exp32.data = '0;
    end
    exp32_rd = rd;
    check("ld_ready_idle", ld_ready, 1'b1);
    ld_valid = 1'b1; ld_addr = a; ld_type = t; ld_rd = rd;
    @(posedge clk); #1;
    t0 = cyc;
    ld_valid = 1'b0; ld_addr = ~a; ld_type = 3'd7; ld_rd = ~rd;
    if (exp32.mem) begin
      for (int i = 0; i < req_wait; i++) begin
        check("req_held", mem_req_valid, 1'b1);
        @(posedge clk); #1;
      end
      check("req_valid", mem_req_valid, 1'b1);
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      check("req_drop", mem_req_valid, 1'b0);
      n = (rsp_wait < 0) ? TO : rsp_wait;
      for (int i = 0; i < n; i++) begin
        check("no_early_res", res_valid, 1'b0);
        @(posedge clk); #1;
      end
      if (rsp_wait >= 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_err = e;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
      end
      lat = 2 + req_wait + ((rsp_wait < 0) ? TO : rsp_wait + 1);
    end else begin
      check("no_mem_access", mem_req_valid, 1'b0);
      lat = 1;
    end
    check("latency", cyc - t0 + 1, lat);
    check("res_valid", res_valid, 1'b1);
    check("lit_data", res_data, lit);
    check("lit_err", {res_err, res_err_code}, {lit_err, lit_code});
    check("lit_rd", res_rd, rd);
    for (int i = 0; i < res_wait; i++) begin
      mem_rsp_valid = (i == 1);
      mem_rsp_data  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      check("res_hold", res_valid, 1'b1);
      check("ld_ready_busy", ld_ready, 1'b0);
    end
    mem_rsp_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_done", res_valid, 1'b0);
    check("back_idle", ld_ready, 1'b1);
  endtask

  task automatic run64(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd,
                       input logic [63:0] d, input logic [63:0] lit,
                       input logic [1:0] lit_code, input bit lit_err);
    int t0;
    exp64 = model(64, t, {32'd0, a}, d, 1'b0);
    exp64_rd = rd;
    check("w_ld_ready_idle", w_ld_ready, 1'b1);
    w_ld_valid = 1'b1; w_ld_addr = a; w_ld_type = t; w_ld_rd = rd;
    @(posedge clk); #1;
    t0 = cyc;
    w_ld_valid = 1'b0; w_ld_addr = ~a;
    if (exp64.mem) begin
      check("w_req_valid", w_mem_req_valid, 1'b1);
      w_mem_req_ready = 1'b1;
      @(posedge clk); #1;
      w_mem_req_ready = 1'b0;
      w_mem_rsp_valid = 1'b1; w_mem_rsp_data = d;
      @(posedge clk); #1;
      w_mem_rsp_valid = 1'b0; w_mem_rsp_data = '0;
    end
    check("w_latency", cyc - t0 + 1, exp64.mem ? 3 : 1);
    check("w_res_valid", w_res_valid, 1'b1);
    check("w_lit_data", w_res_data, lit);
    check("w_lit_err", {w_res_err, w_res_err_code}, {lit_err, lit_code});
    w_res_ready = 1'b1;
    @(posedge clk); #1;
    w_res_ready = 1'b0;
    check("w_res_done", w_res_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_type = '0; ld_rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    res_ready = 1'b0;
    w_ld_valid = 1'b0; w_ld_addr = '0; w_ld_type = '0; w_ld_rd = '0;
    w_mem_req_ready = 1'b0; w_mem_rsp_valid = 1'b0; w_mem_rsp_data = '0; w_mem_rsp_err = 1'b0;
    w_res_ready = 1'b0;

    @(posedge clk); #1;
    check("rst_ld_ready", ld_ready, 1'b1);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_res", {res_valid, res_err, res_err_code, res_rd}, 9'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_w_ld_ready", w_ld_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("idle_res_ready_valid", res_valid, 1'b0);
    check("idle_res_ready_ready", ld_ready, 1'b1);

    run_load(3'd0, 32'h1003, 5'd1, 32'h80FF_7F01, 1'b0, 0, 0, 0, 32'hFFFF_FF80, 2'd0, 1'b0);
    check("lit_req_addr", mem_req_addr, 32'h1000);
    run_load(3'd4, 32'h1002, 5'd2, 32'h80FF_7F01, 1'b0, 0, 0, 0, 32'h0000_00FF, 2'd0, 1'b0);
    run_load(3'd1, 32'h1002, 5'd3, 32'h80FF_7F01, 1'b0, 0, 1, 0, 32'hFFFF_80FF, 2'd0, 1'b0);
    run_load(3'd5, 32'h1000, 5'd4, 32'h80FF_7F01, 1'b0, 1, 0, 1, 32'h0000_7F01, 2'd0, 1'b0);
    run_load(3'd2, 32'h2000, 5'd5, 32'h1234_5678, 1'b0, 5, 1, 3, 32'h1234_5678, 2'd0, 1'b0);
    run_load(3'd2, 32'h2001, 5'd6, 32'h0, 1'b0, 0, 0, 2, 32'h0, 2'd0, 1'b1);
    run_load(3'd3, 32'h2000, 5'd7, 32'h0, 1'b0, 0, 0, 0, 32'h0, 2'd1, 1'b1);
    run_load(3'd3, 32'h2001, 5'd8, 32'h0, 1'b0, 0, 0, 0, 32'h0, 2'd1, 1'b1);
    run_load(3'd6, 32'h2000, 5'd9, 32'h0, 1'b0, 0, 0, 0, 32'h0, 2'd1, 1'b1);
    run_load(3'd7, 32'h2000, 5'd10, 32'h0, 1'b0, 0, 0, 0, 32'h0, 2'd1, 1'b1);
    run_load(3'd1, 32'h1001, 5'd11, 32'h0, 1'b0, 0, 0, 0, 32'h0, 2'd0, 1'b1);
    run_load(3'd5, 32'h1003, 5'd12, 32'h0, 1'b0, 0, 0, 0, 32'h0, 2'd0, 1'b1);
    // Response lands in the very cycle the timeout would expire.
    run_load(3'd0, 32'h1001, 5'd13, 32'h80FF_7F01, 1'b0, 0, TO - 1, 0, 32'h0000_007F, 2'd0, 1'b0);
    // No response: timeout, with a late response during RESP and another in IDLE.
    run_load(3'd2, 32'h4000, 5'd14, 32'h0, 1'b0, 0, -1, 3, 32'h0, 2'd3, 1'b1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check("stray_rsp_res", res_valid, 1'b0);
    check("stray_rsp_ready", ld_ready, 1'b1);
    run_load(3'd1, 32'h4002, 5'd15, 32'hA5A5_1234, 1'b0, 2, 2, 1, 32'hFFFF_A5A5, 2'd0, 1'b0);
    run_load(3'd0, 32'h3000, 5'd16, 32'h1234_5678, 1'b1, 0, 2, 0, 32'h0, 2'd2, 1'b1);

    // Asynchronous reset while in WAIT.
    exp32 = model(32, 3'd2, 64'h5000, 64'h1111_2222, 1'b0);
    exp32_rd = 5'd18;
    ld_valid = 1'b1; ld_addr = 32'h5000; ld_type = 3'd2; ld_rd = 5'd18;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_busy", ld_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ld_ready", ld_ready, 1'b1);
    check("arst_req_valid", mem_req_valid, 1'b0);
    check("arst_req_addr", mem_req_addr, 32'h0);
    check("arst_res", {res_valid, res_err, res_err_code, res_rd}, 9'h0);
    check("arst_res_data", res_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check("post_rst_rsp_res", res_valid, 1'b0);
    check("post_rst_rsp_ready", ld_ready, 1'b1);
    run_load(3'd2, 32'h6004, 5'd17, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 32'hCAFE_F00D, 2'd0, 1'b0);

    run64(3'd2, 32'h8, 5'd1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 2'd0, 1'b0);
    run64(3'd6, 32'hC, 5'd2, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001, 2'd0, 1'b0);
    run64(3'd3, 32'h10, 5'd3, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, 2'd0, 1'b0);
    run64(3'd0, 32'h17, 5'd4, 64'hFE00_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 2'd0, 1'b0);
    run64(3'd5, 32'h1E, 5'd7, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, 2'd0, 1'b0);
    run64(3'd3, 32'h14, 5'd5, 64'h0, 64'h0, 2'd0, 1'b1);
    run64(3'd7, 32'h10, 5'd6, 64'h0, 64'h0, 2'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
